if_fetch_stage: RTL and testbench

Instruction-fetch stage with integrated IF/ID pipeline register. Sits directly upstream of the ID stage and feeds the decoder, which in turn feeds the ID/EX register.
- Owns the PC.
- Issues one instruction-memory request at a time.
- Holds the returned instruction under downstream stall.
- Discards in-flight fetches on branch/jump redirect.

---
 rtl/if_fetch_stage_pkg.sv | 29 ++
 rtl/if_fetch_stage_if_id_reg.sv | 63 ++++++
 rtl/if_fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_fetch_stage_pkg;

    // Default datapath / PC width.
    localparam int XLEN = 32;

    // Bubble encoding: addi x0,x0,0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch sequencer states.
    //   ISSUE : request is on the bus this cycle
    //   WAIT  : request accepted, response not yet seen
    //   DROP  : a response is still owed but belongs to a squashed fetch
    //   HOLD  : response captured, waiting for the decoder to accept it
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    // True in the states where the stage is waiting on memory or on the decoder.
    function automatic logic is_stalled_state(input fetch_state_t s);
        return (s == WAIT) || (s == HOLD);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction with its PC and PC+4.
// Latency: 1 cycle from load to outputs.
// Backpressure: stall freezes contents; flush overrides stall and inserts a bubble.
//
// Ports:
//   clk, reset (sync, active-low)
//   flush, stall          hazard-unit controls
//   load, load_instr,
//   load_pc, load_pc_add4 new entry offered by the fetch sequencer
//   instr, pc, pc_add4,
//   valid                 registered IF/ID contents to the decoder
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int          W      = 32,
    parameter logic [31:0] BUBBLE = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         stall,
    input  logic         load,
    input  logic [31:0]  load_instr,
    input  logic [W-1:0] load_pc,
    input  logic [W-1:0] load_pc_add4,
    output logic [31:0]  instr,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_add4,
    output logic         valid
);

    // Priority: reset > flush > stall > load > bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr   <= BUBBLE;
            pc      <= '0;
            pc_add4 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            instr   <= BUBBLE;
            pc      <= '0;
            pc_add4 <= '0;
            valid   <= 1'b0;
        end else if (stall) begin
            instr   <= instr;
            pc      <= pc;
            pc_add4 <= pc_add4;
            valid   <= valid;
        end else if (load) begin
            instr   <= load_instr;
            pc      <= load_pc;
            pc_add4 <= load_pc_add4;
            valid   <= 1'b1;
        end else begin
            // Nothing new arrived and the decoder consumed the old entry.
            instr   <= BUBBLE;
            pc      <= '0;
            pc_add4 <= '0;
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, feeds IF/ID.
// Latency: request to IF/ID valid is memory latency + 1 cycle; 1 instr per 2 cycles at best.
// Backpressure: stall parks a returned instruction in a hold register and stops new requests.
//
// Ports:
//   clk, reset (sync, active-low)
//   stall, flush                   hazard unit
//   redirect, redirect_pc          taken branch/jump from EX
//   imem_req, imem_addr            request strobe / address (decoded from state only)
//   imem_valid, imem_rdata         response strobe / instruction
//   instrOut, pcOut, pcAdd4Out,
//   validOut                       IF/ID register contents
//   perf_fetched, perf_stall_cycles  only when FETCH_PERF_COUNTERS_EN is defined
module if_fetch_stage #(
    parameter int              XLEN      = if_fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instrOut,
    output logic [XLEN-1:0] pcOut,
    output logic [XLEN-1:0] pcAdd4Out,
    output logic            validOut
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall_cycles
`endif
);

    import if_fetch_stage_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_add4;
    logic [31:0]     hold_instr;

    logic            load_cand;
    logic            load_vld;
    logic [31:0]     load_instr;

    // Wraps modulo 2^XLEN by construction.
    assign pc_add4 = pc + PC_STEP;

    // Request interface depends on registered state only.
    assign imem_req  = (state == ISSUE);
    assign imem_addr = pc;

    // An instruction is ready to enter IF/ID: a fresh response in WAIT or the
    // parked one in HOLD, with no redirect squashing it and the decoder free.
    assign load_cand  = !redirect && !stall &&
                        (((state == WAIT) && imem_valid) || (state == HOLD));
    // A flush in the same cycle wins over the load; the FSM then keeps the
    // instruction parked instead of advancing.
    assign load_vld   = load_cand && !flush;
    assign load_instr = (state == HOLD) ? hold_instr : imem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ISSUE;
            pc         <= RESET_PC;
            hold_instr <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    // The request already left this cycle, so a redirect must
                    // still swallow its response.
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= DROP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= imem_valid ? ISSUE : DROP;
                    end else if (imem_valid) begin
                        if (load_vld) begin
                            pc    <= pc_add4;
                            state <= ISSUE;
                        end else begin
                            hold_instr <= imem_rdata;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc         <= redirect_pc;
                        hold_instr <= '0;
                        state      <= ISSUE;
                    end else if (load_vld) begin
                        pc    <= pc_add4;
                        state <= ISSUE;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    if (imem_valid) begin
                        state <= ISSUE;
                    end
                end
                default: begin
                    state <= ISSUE;
                end
            endcase
        end
    end

    if_id_reg #(
        .W      (XLEN),
        .BUBBLE (NOP_INSTR)
    ) u_if_id_reg (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .stall        (stall),
        .load         (load_cand),
        .load_instr   (load_instr),
        .load_pc      (pc),
        .load_pc_add4 (pc_add4),
        .instr        (instrOut),
        .pc           (pcOut),
        .pc_add4      (pcAdd4Out),
        .valid        (validOut)
    );

`ifdef FETCH_PERF_COUNTERS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (load_vld && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (is_stalled_state(state) && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: cycle-by-cycle vector table plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_if_fetch_stage;

    localparam logic [31:0] N = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic [31:0] pcAdd4Out;
    logic        validOut;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
`ifdef FETCH_PERF_COUNTERS_EN
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instrOut    (instrOut),
        .pcOut       (pcOut),
        .pcAdd4Out   (pcAdd4Out),
        .validOut    (validOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs applied for one cycle + outputs expected during that
    // cycle (i.e. state left by the previous edge).
    // chk: 0 = no check, 1 = all outputs, 2 = skip pcOut/pcAdd4Out (bubble rows)
    typedef struct {
        logic        rst, st, fl, rd;
        logic [31:0] rpc;
        logic        iv;
        logic [31:0] rdat;
        logic [1:0]  chk;
        logic        req;
        logic [31:0] addr, instr, pc, pc4;
        logic        vld;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, st, fl, rd, input logic [31:0] rpc,
                                input logic iv, input logic [31:0] rdat, input logic [1:0] chk,
                                input logic req, input logic [31:0] addr, instr, pc, pc4,
                                input logic vld);
        vec_t v;
        v.rst = rst; v.st = st; v.fl = fl; v.rd = rd; v.rpc = rpc;
        v.iv = iv; v.rdat = rdat; v.chk = chk; v.req = req; v.addr = addr;
        v.instr = instr; v.pc = pc; v.pc4 = pc4; v.vld = vld;
        return v;
    endfunction

    task automatic drive(input logic rst, st, fl, rd, input logic [31:0] rpc,
                         input logic iv, input logic [31:0] rdat);
        @(negedge clk);
        reset = rst; stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
        imem_valid = iv; imem_rdata = rdat;
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] chk, input logic req,
                         input logic [31:0] addr, instr, pc, pc4, input logic vld);
        logic ok;
        ok = (imem_req === req) && (imem_addr === addr) && (instrOut === instr) &&
             (validOut === vld);
        if (chk == 2'd1) ok = ok && (pcOut === pc) && (pcAdd4Out === pc4);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got req=%0b addr=%h instr=%h pc=%h pc4=%h vld=%0b ; want req=%0b addr=%h instr=%h pc=%h pc4=%h vld=%0b%s",
                     name, imem_req, imem_addr, instrOut, pcOut, pcAdd4Out, validOut,
                     req, addr, instr, pc, pc4, vld, (chk == 2'd2) ? " (pc fields ignored)" : "");
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        redirect_pc = '0; imem_valid = 1'b0; imem_rdata = '0;

        //                rst st fl rd rpc           iv rdat          chk req addr          instr         pc            pc4           vld
        // reset state, first fetch with 1-cycle memory
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            0,            0,            0,            0)); // 0
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,            1, 1, 0,            N,            0,            0,            0)); // 1
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 1, 0,            N,            0,            0,            0)); // 2
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 32'h00500093, 1, 0, 0,            N,            0,            0,            0)); // 3
        // stall across a response: held for 3 cycles, then loaded
        tbl.push_back(mk(1, 1, 0, 0, 0,            0, 0,            1, 1, 4,            32'h00500093, 0,            4,            1)); // 4
        tbl.push_back(mk(1, 1, 0, 0, 0,            1, 32'h00A00113, 1, 0, 4,            32'h00500093, 0,            4,            1)); // 5
        tbl.push_back(mk(1, 1, 0, 0, 0,            0, 0,            1, 0, 4,            32'h00500093, 0,            4,            1)); // 6
        tbl.push_back(mk(1, 1, 0, 0, 0,            0, 0,            1, 0, 4,            32'h00500093, 0,            4,            1)); // 7
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 0, 4,            32'h00500093, 0,            4,            1)); // 8
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 1, 8,            32'h00A00113, 4,            8,            1)); // 9
        // redirect in WAIT, response two cycles later is dropped
        tbl.push_back(mk(1, 0, 0, 1, 32'h40,       0, 0,            2, 0, 8,            N,            0,            0,            0)); // 10
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            2, 0, 32'h40,       N,            0,            0,            0)); // 11
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 32'h00100093, 2, 0, 32'h40,       N,            0,            0,            0)); // 12
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            2, 1, 32'h40,       N,            0,            0,            0)); // 13
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 32'h00300193, 2, 0, 32'h40,       N,            0,            0,            0)); // 14
        // flush with stall while IF/ID is valid; parked fetch loads after stall
        tbl.push_back(mk(1, 1, 0, 0, 0,            0, 0,            1, 1, 32'h44,       32'h00300193, 32'h40,       32'h44,       1)); // 15
        tbl.push_back(mk(1, 1, 0, 0, 0,            1, 32'h00400213, 1, 0, 32'h44,       32'h00300193, 32'h40,       32'h44,       1)); // 16
        tbl.push_back(mk(1, 1, 1, 0, 0,            0, 0,            1, 0, 32'h44,       32'h00300193, 32'h40,       32'h44,       1)); // 17
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 0, 32'h44,       N,            0,            0,            0)); // 18
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 1, 32'h48,       32'h00400213, 32'h44,       32'h48,       1)); // 19
        // flush blocks a WAIT load: instruction parks in HOLD and loads next cycle
        tbl.push_back(mk(1, 0, 1, 0, 0,            1, 32'h00500293, 2, 0, 32'h48,       N,            0,            0,            0)); // 20
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 0, 32'h48,       N,            0,            0,            0)); // 21
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 1, 32'h4C,       32'h00500293, 32'h48,       32'h4C,       1)); // 22
        // reset in WAIT, stale response right after release is ignored
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,            2, 0, 32'h4C,       N,            0,            0,            0)); // 23
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 32'h11111111, 1, 1, 0,            N,            0,            0,            0)); // 24
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            2, 0, 0,            N,            0,            0,            0)); // 25
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 32'h00600313, 2, 0, 0,            N,            0,            0,            0)); // 26
        // redirect in ISSUE to the top of the address space; PC+4 wraps
        tbl.push_back(mk(1, 0, 0, 1, 32'hFFFFFFFC, 0, 0,            1, 1, 4,            32'h00600313, 0,            4,            1)); // 27
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 32'h22222222, 2, 0, 32'hFFFFFFFC, N,            0,            0,            0)); // 28
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            2, 1, 32'hFFFFFFFC, N,            0,            0,            0)); // 29
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 32'h00700393, 2, 0, 32'hFFFFFFFC, N,            0,            0,            0)); // 30
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 1, 0,            32'h00700393, 32'hFFFFFFFC, 0,            1)); // 31
        // redirect with a same-cycle response; redirect out of HOLD
        tbl.push_back(mk(1, 0, 0, 1, 32'h80,       1, 32'h33333333, 2, 0, 0,            N,            0,            0,            0)); // 32
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            2, 1, 32'h80,       N,            0,            0,            0)); // 33
        tbl.push_back(mk(1, 1, 0, 0, 0,            1, 32'h00800413, 2, 0, 32'h80,       N,            0,            0,            0)); // 34
        tbl.push_back(mk(1, 1, 0, 1, 32'h100,      0, 0,            2, 0, 32'h80,       N,            0,            0,            0)); // 35
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            2, 1, 32'h100,      N,            0,            0,            0)); // 36
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 32'h00900493, 2, 0, 32'h100,      N,            0,            0,            0)); // 37
        tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,            1, 1, 32'h104,      32'h00900493, 32'h100,      32'h104,      1)); // 38

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].fl, tbl[i].rd, tbl[i].rpc, tbl[i].iv, tbl[i].rdat);
            if (tbl[i].chk != 2'd0)
                check($sformatf("row%0d", i), tbl[i].chk, tbl[i].req, tbl[i].addr,
                      tbl[i].instr, tbl[i].pc, tbl[i].pc4, tbl[i].vld);
        end

        // Repeated redirects while in DROP: last target wins, response still swallowed.
        drive(1, 0, 0, 1, 32'h200, 0, 0);
        check("drop_a", 2'd2, 1'b0, 32'h104, N, 0, 0, 1'b0);
        drive(1, 0, 0, 1, 32'h300, 0, 0);
        check("drop_b", 2'd2, 1'b0, 32'h200, N, 0, 0, 1'b0);
        drive(1, 0, 0, 1, 32'h400, 1, 32'h44444444);
        check("drop_c", 2'd2, 1'b0, 32'h300, N, 0, 0, 1'b0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("drop_d", 2'd2, 1'b1, 32'h400, N, 0, 0, 1'b0);

        // Back-to-back fetches with 1-cycle memory: one instruction every 2 cycles.
        drive(1, 0, 0, 0, 0, 1, 32'h000A0013);
        check("stream_first", 2'd2, 1'b0, 32'h400, N, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'h404 + 32'(4 * k);
            drive(1, 0, 0, 0, 0, 0, 0);
            check($sformatf("stream_ld%0d", k), 2'd1, 1'b1, a, 32'h000A0013 + 32'(k),
                  a - 32'h4, a, 1'b1);
            drive(1, 0, 0, 0, 0, 1, 32'h000A0014 + 32'(k));
            check($sformatf("stream_bub%0d", k), 2'd2, 1'b0, a, N, 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
